sevga_snoop_fifo: RTL and testbench

- Write-posting buffer between the CPU bus snoop decoder and the VRAM port of the SE-VGA adapter.
- Captures each decoded framebuffer write from the 68000 bus (address, data, byte strobes) into a small FIFO clocked by pixClk.
- Drains queued entries to VRAM one byte per cycle, only in slots not owned by the video fetch. CPU bursts therefore no longer collide with VRAM reads.
- Outputs feed the top-level VRAM address/data/strobe mux as the CPU-side write source.

---
 rtl/sevga_snoop_fifo.sv | 196 +++++++++++++++++++
 tb/tb_sevga_snoop_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevga_snoop_fifo.sv
// Write-posting FIFO between the 68000 framebuffer-write decoder and the VRAM port.
// CPU writes are captured via synchronised strobes and drained one byte per free VRAM slot.
module sevga_snoop_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 15
) (
    input  logic                     pixClk,
    input  logic                     nReset,
    input  logic                     cpuHit,
    input  logic                     cpuBufSel,
    input  logic [13:0]              cpuWordAddr,
    input  logic [15:0]              cpuData,
    input  logic                     ncpuAS,
    input  logic                     ncpuUDS,
    input  logic                     ncpuLDS,
    input  logic                     readSlot,
    output logic [AW-1:0]            wrAddr,
    output logic [7:0]               wrData,
    output logic                     nwrWE,
    output logic                     nwrCE0,
    output logic                     nwrCE1,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic        bufSel;
        logic [13:0] wordAddr;
        logic [15:0] data;
        logic        ude;
        logic        lde;
    } entryT;

    typedef enum logic { C_IDLE, C_WAIT_END } capStateT;
    typedef enum logic [1:0] { D_IDLE, D_HI, D_LO, D_HOLD } drainStateT;

    // Two-flop synchronisers; strobes idle high, hit idles low.
    logic [1:0] asSync, udsSync, ldsSync, hitSync;
    logic       syncAS, syncUDS, syncLDS, syncHit;

    always_ff @(negedge pixClk or negedge nReset) begin
        if (!nReset) begin
            asSync  <= 2'b11;
            udsSync <= 2'b11;
            ldsSync <= 2'b11;
            hitSync <= 2'b00;
        end else begin
            asSync  <= {asSync[0], ncpuAS};
            udsSync <= {udsSync[0], ncpuUDS};
            ldsSync <= {ldsSync[0], ncpuLDS};
            hitSync <= {hitSync[0], cpuHit};
        end
    end

    assign syncAS  = asSync[1];
    assign syncUDS = udsSync[1];
    assign syncLDS = ldsSync[1];
    assign syncHit = hitSync[1];

    // Capture FSM: one request per bus cycle, re-armed only once AS returns high.
    capStateT cState, cNext;
    logic     capReq;

    always_ff @(negedge pixClk or negedge nReset) begin
        if (!nReset) cState <= C_IDLE;
        else         cState <= cNext;
    end

    always_comb begin
        cNext  = cState;
        capReq = 1'b0;
        case (cState)
            C_IDLE: begin
                if (!syncAS && syncHit && (!syncUDS || !syncLDS)) begin
                    capReq = 1'b1;
                    cNext  = C_WAIT_END;
                end
            end
            C_WAIT_END: begin
                if (syncAS) cNext = C_IDLE;
            end
            default: cNext = C_IDLE;
        endcase
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    entryT           mem [DEPTH];
    logic [PW-1:0]   wrPtr, rdPtr;
    logic [CW-1:0]   count;
    logic            full, push, pop;
    entryT           newEntry, head;
    logic [AW-1:0]   headAddr;

    assign full      = (count == CW'(DEPTH));
    assign push      = capReq && (!full || pop);
    assign head      = mem[rdPtr];
    assign headAddr  = AW'({head.bufSel, head.wordAddr});
    assign fifoCount = count;

    always_comb begin
        newEntry.bufSel   = cpuBufSel;
        newEntry.wordAddr = cpuWordAddr;
        newEntry.data     = cpuData;
        newEntry.ude      = ~syncUDS;
        newEntry.lde      = ~syncLDS;
    end

    always_ff @(negedge pixClk) begin
        if (push) mem[wrPtr] <= newEntry;
    end

    always_ff @(negedge pixClk or negedge nReset) begin
        if (!nReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (capReq && full && !pop) overflow <= 1'b1;
        end
    end

    // Drain FSM: entry into a write state only on an edge where readSlot was low,
    // so a strobe never lands in a fetch-owned cycle.
    drainStateT dState, dNext;

    always_comb begin
        dNext = dState;
        pop   = 1'b0;
        case (dState)
            D_IDLE: begin
                if (count != '0 && !readSlot) dNext = head.ude ? D_HI : D_LO;
            end
            D_HI: begin
                if (head.lde) begin
                    dNext = readSlot ? D_HOLD : D_LO;
                end else begin
                    pop   = 1'b1;
                    dNext = D_IDLE;
                end
            end
            D_HOLD: begin
                if (!readSlot) dNext = D_LO;
            end
            D_LO: begin
                pop   = 1'b1;
                dNext = D_IDLE;
            end
            default: dNext = D_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(negedge pixClk or negedge nReset) begin
        if (!nReset) begin
            dState <= D_IDLE;
            nwrWE  <= 1'b1;
            nwrCE0 <= 1'b1;
            nwrCE1 <= 1'b1;
            wrAddr <= '0;
            wrData <= '0;
        end else begin
            dState <= dNext;
            nwrWE  <= 1'b1;
            nwrCE0 <= 1'b1;
            nwrCE1 <= 1'b1;
            case (dNext)
                D_HI: begin
                    nwrWE  <= 1'b0;
                    nwrCE0 <= 1'b0;
                    wrAddr <= headAddr;
                    wrData <= head.data[15:8];
                end
                D_LO: begin
                    nwrWE  <= 1'b0;
                    nwrCE1 <= 1'b0;
                    wrAddr <= headAddr;
                    wrData <= head.data[7:0];
                end
                D_HOLD: wrAddr <= headAddr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sevga_snoop_fifo.sv
// Directed bench for sevga_snoop_fifo: expected VRAM byte writes are queued as stimulus is
// issued and a monitor pops/compares them whenever the write strobe is low.
module tb_sevga_snoop_fifo;

    logic        pixClk = 1'b0;
    logic        nReset;
    logic        cpuHit;
    logic        cpuBufSel;
    logic [13:0] cpuWordAddr;
    logic [15:0] cpuData;
    logic        ncpuAS, ncpuUDS, ncpuLDS;
    logic        readSlot;
    logic [14:0] wrAddr;
    logic [7:0]  wrData;
    logic        nwrWE, nwrCE0, nwrCE1;
    logic [2:0]  fifoCount;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    sevga_snoop_fifo #(.DEPTH(4), .AW(15)) dut (
        .pixClk(pixClk), .nReset(nReset), .cpuHit(cpuHit), .cpuBufSel(cpuBufSel),
        .cpuWordAddr(cpuWordAddr), .cpuData(cpuData), .ncpuAS(ncpuAS), .ncpuUDS(ncpuUDS),
        .ncpuLDS(ncpuLDS), .readSlot(readSlot), .wrAddr(wrAddr), .wrData(wrData),
        .nwrWE(nwrWE), .nwrCE0(nwrCE0), .nwrCE1(nwrCE1), .fifoCount(fifoCount),
        .overflow(overflow)
    );

    always #20 pixClk = ~pixClk;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
        logic        hi;
    } expT;

    expT sbq[$];
    expT monE;
    logic rsAtEdge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expectWord(input logic bs, input logic [13:0] wa, input logic [15:0] d,
                              input logic u, input logic l);
        expT e;
        e.addr = {bs, wa};
        if (u) begin e.data = d[15:8]; e.hi = 1'b1; sbq.push_back(e); end
        if (l) begin e.data = d[7:0];  e.hi = 1'b0; sbq.push_back(e); end
    endtask

    task automatic busIdle();
        ncpuAS = 1'b1; ncpuUDS = 1'b1; ncpuLDS = 1'b1; cpuHit = 1'b0;
    endtask

    task automatic startWrite(input logic bs, input logic [13:0] wa, input logic [15:0] d,
                              input logic u, input logic l);
        cpuBufSel = bs; cpuWordAddr = wa; cpuData = d;
        ncpuUDS = !u; ncpuLDS = !l; ncpuAS = 1'b0; cpuHit = 1'b1;
    endtask

    task automatic cpuWrite(input logic bs, input logic [13:0] wa, input logic [15:0] d,
                            input logic u, input logic l, input int hold);
        @(posedge pixClk);
        startWrite(bs, wa, d, u, l);
        repeat (hold) @(posedge pixClk);
        busIdle();
        repeat (4) @(posedge pixClk);
    endtask

    always @(negedge pixClk) rsAtEdge <= readSlot;

    // Monitor: every low write strobe must match the next queued byte.
    always @(posedge pixClk) begin
        if (nReset && !nwrWE) begin
            check("ce one-hot", {31'd0, nwrCE0 ^ nwrCE1}, 1);
            check("write after readSlot", {31'd0, rsAtEdge}, 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected write: addr=%0h data=%0h ce0=%0b ce1=%0b expected none",
                         wrAddr, wrData, nwrCE0, nwrCE1);
            end else begin
                monE = sbq.pop_front();
                check("wr addr", {17'd0, wrAddr}, {17'd0, monE.addr});
                check("wr data", {24'd0, wrData}, {24'd0, monE.data});
                check("wr ce0", {31'd0, nwrCE0}, {31'd0, !monE.hi});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        nReset = 1'b0; readSlot = 1'b0;
        cpuBufSel = 1'b0; cpuWordAddr = '0; cpuData = '0;
        busIdle();
        repeat (3) @(posedge pixClk);
        check("rst nwrWE", {31'd0, nwrWE}, 1);
        check("rst nwrCE0", {31'd0, nwrCE0}, 1);
        check("rst nwrCE1", {31'd0, nwrCE1}, 1);
        check("rst wrAddr", {17'd0, wrAddr}, 0);
        check("rst wrData", {24'd0, wrData}, 0);
        check("rst count", {29'd0, fifoCount}, 0);
        check("rst overflow", {31'd0, overflow}, 0);
        @(posedge pixClk); nReset = 1'b1;
        repeat (2) @(posedge pixClk);

        // Single word write: exact 4-edge latency, high then low byte.
        expectWord(1'b1, 14'h1380, 16'hA55A, 1'b1, 1'b1);
        @(posedge pixClk);
        startWrite(1'b1, 14'h1380, 16'hA55A, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge pixClk);
            case (k)
                3: begin
                    check("t1 count pushed", {29'd0, fifoCount}, 1);
                    check("t1 no early write", {31'd0, nwrWE}, 1);
                end
                4: begin
                    check("t1 hi nwrWE", {31'd0, nwrWE}, 0);
                    check("t1 hi ce0", {31'd0, nwrCE0}, 0);
                    check("t1 hi addr", {17'd0, wrAddr}, 32'h5380);
                    busIdle();
                end
                5: begin
                    check("t1 lo ce1", {31'd0, nwrCE1}, 0);
                    check("t1 lo ce0", {31'd0, nwrCE0}, 1);
                    check("t1 lo addr", {17'd0, wrAddr}, 32'h5380);
                end
                6: begin
                    check("t1 done nwrWE", {31'd0, nwrWE}, 1);
                    check("t1 count empty", {29'd0, fifoCount}, 0);
                end
                default: ;
            endcase
        end
        repeat (4) @(posedge pixClk);

        // Single-strobe writes.
        expectWord(1'b0, 14'h0100, 16'h1234, 1'b1, 1'b0);
        cpuWrite(1'b0, 14'h0100, 16'h1234, 1'b1, 1'b0, 4);
        expectWord(1'b1, 14'h0200, 16'h00CD, 1'b0, 1'b1);
        cpuWrite(1'b1, 14'h0200, 16'h00CD, 1'b0, 1'b1, 4);
        repeat (4) @(posedge pixClk);
        check("t2 count", {29'd0, fifoCount}, 0);

        // readSlot high across D_HI exit: three hold cycles, then the low byte.
        expectWord(1'b0, 14'h0042, 16'hBEEF, 1'b1, 1'b1);
        @(posedge pixClk);
        startWrite(1'b0, 14'h0042, 16'hBEEF, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge pixClk);
            if (k == 4) begin
                check("t3 hi ce0", {31'd0, nwrCE0}, 0);
                busIdle();
                readSlot = 1'b1;
            end else if (k >= 5 && k <= 7) begin
                check("t3 hold nwrWE", {31'd0, nwrWE}, 1);
                check("t3 hold ces", {30'd0, nwrCE0, nwrCE1}, 3);
                check("t3 hold addr", {17'd0, wrAddr}, 32'h0042);
                if (k == 7) readSlot = 1'b0;
            end else if (k == 8) begin
                check("t3 lo ce1", {31'd0, nwrCE1}, 0);
            end
        end
        repeat (4) @(posedge pixClk);

        // No drain start while readSlot stays high.
        readSlot = 1'b1;
        expectWord(1'b0, 14'h0010, 16'h0077, 1'b0, 1'b1);
        cpuWrite(1'b0, 14'h0010, 16'h0077, 1'b0, 1'b1, 4);
        repeat (8) @(posedge pixClk);
        check("t3b held count", {29'd0, fifoCount}, 1);
        check("t3b held nwrWE", {31'd0, nwrWE}, 1);
        readSlot = 1'b0;
        repeat (5) @(posedge pixClk);
        check("t3b drained", {29'd0, fifoCount}, 0);

        // Overflow: DEPTH+1 writes with the fetch owning VRAM; only the first four drain.
        readSlot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expectWord(1'b1, 14'h0300 + 14'(i), 16'h1111 * 16'(i + 1), 1'b1, 1'b1);
            cpuWrite(1'b1, 14'h0300 + 14'(i), 16'h1111 * 16'(i + 1), 1'b1, 1'b1, 4);
        end
        check("t4 count full", {29'd0, fifoCount}, 4);
        check("t4 overflow", {31'd0, overflow}, 1);
        readSlot = 1'b0;
        repeat (20) @(posedge pixClk);
        check("t4 drained", {29'd0, fifoCount}, 0);
        check("t4 sb empty", sbq.size(), 0);

        // Mid-run reset clears the sticky overflow.
        nReset = 1'b0;
        #1;
        check("t4 rst overflow", {31'd0, overflow}, 0);
        @(posedge pixClk); nReset = 1'b1;
        repeat (2) @(posedge pixClk);

        // AS held low for 20 cycles: exactly one push.
        readSlot = 1'b1;
        expectWord(1'b0, 14'h0555, 16'hC3C3, 1'b1, 1'b1);
        cpuWrite(1'b0, 14'h0555, 16'hC3C3, 1'b1, 1'b1, 20);
        check("t5 single push", {29'd0, fifoCount}, 1);
        readSlot = 1'b0;
        repeat (8) @(posedge pixClk);
        check("t5 drained", {29'd0, fifoCount}, 0);

        // Push into a full FIFO on the same edge as a pop.
        readSlot = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expectWord(1'b0, 14'h0020 + 14'(i), 16'h0011 * 16'(i + 1), 1'b0, 1'b1);
            cpuWrite(1'b0, 14'h0020 + 14'(i), 16'h0011 * 16'(i + 1), 1'b0, 1'b1, 4);
        end
        expectWord(1'b0, 14'h0024, 16'h0099, 1'b0, 1'b1);
        @(posedge pixClk);
        startWrite(1'b0, 14'h0024, 16'h0099, 1'b0, 1'b1);
        @(posedge pixClk); readSlot = 1'b0;
        @(posedge pixClk);
        check("t5b pre count", {29'd0, fifoCount}, 4);
        @(posedge pixClk);
        check("t5b push+pop count", {29'd0, fifoCount}, 4);
        check("t5b overflow", {31'd0, overflow}, 0);
        @(posedge pixClk); busIdle();
        repeat (20) @(posedge pixClk);
        check("t5b drained", {29'd0, fifoCount}, 0);
        check("t5b sb empty", sbq.size(), 0);

        // Reset during D_HI with two entries queued.
        readSlot = 1'b1;
        expectWord(1'b1, 14'h0700, 16'hF00D, 1'b1, 1'b0);
        cpuWrite(1'b1, 14'h0700, 16'hF00D, 1'b1, 1'b1, 4);
        cpuWrite(1'b1, 14'h0701, 16'hCAFE, 1'b1, 1'b1, 4);
        check("t6 queued", {29'd0, fifoCount}, 2);
        readSlot = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge pixClk);
            if (!nwrWE) seen = 1'b1;
        end
        check("t6 reached D_HI", {31'd0, seen}, 1);
        #5 nReset = 1'b0;
        #1;
        check("t6 rst nwrWE", {31'd0, nwrWE}, 1);
        check("t6 rst nwrCE0", {31'd0, nwrCE0}, 1);
        check("t6 rst count", {29'd0, fifoCount}, 0);
        repeat (2) @(posedge pixClk);
        nReset = 1'b1;
        repeat (20) @(posedge pixClk);
        check("t6 idle count", {29'd0, fifoCount}, 0);
        check("t6 sb empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
